// File: rtl/time_pkg.sv
// Shared definitions for the nap clock: FSM states, BCD digit
// limits, field offsets of the packed HH:MM:SS word and a legality check.
package time_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_RING = 2'd2
  } state_e;

  localparam logic [3:0] DMAX9 = 4'd9;
  localparam logic [3:0] DMAX5 = 4'd5;
  localparam logic [3:0] DMAX2 = 4'd2;
  localparam logic [3:0] DMAX3 = 4'd3;

  localparam int H10_LSB = 20;
  localparam int H1_LSB  = 16;
  localparam int M10_LSB = 12;
  localparam int M1_LSB  = 8;
  localparam int S10_LSB = 4;
  localparam int S1_LSB  = 0;

  function automatic logic time_legal(input logic [23:0] t);
    logic [3:0] h10, h1, m10, m1, s10, s1;
    h10 = t[H10_LSB +: 4];
    h1  = t[H1_LSB +: 4];
    m10 = t[M10_LSB +: 4];
    m1  = t[M1_LSB +: 4];
    s10 = t[S10_LSB +: 4];
    s1  = t[S1_LSB +: 4];
    return (h10 <= DMAX2) && (h1 <= DMAX9) &&
           !((h10 == DMAX2) && (h1 > DMAX3)) &&
           (m10 <= DMAX5) && (m1 <= DMAX9) &&
           (s10 <= DMAX5) && (s1 <= DMAX9);
  endfunction

endpackage

// File: rtl/nap_clock_if.sv
// Control and status bundle of the nap clock, as seen by a
// controller (master) and by the clock block (slave).
interface nap_clock_if;

  logic        tick;
  logic        set_en;
  logic [23:0] set_time;
  logic        start;
  logic        stop;
  logic        target_load;
  logic [23:0] target_time;
  logic        alarm_ack;
  logic [3:0]  oHour10;
  logic [3:0]  oHour1;
  logic [3:0]  oMinute10;
  logic [3:0]  oMinute1;
  logic [3:0]  oSecond10;
  logic [3:0]  oSecond1;
  logic        alarm;
  logic        target_valid;
  logic        set_err;
  logic        day_wrap;

  modport master (
    output tick, set_en, set_time, start, stop,
    output target_load, target_time, alarm_ack,
    input  oHour10, oHour1, oMinute10, oMinute1,
    input  oSecond10, oSecond1,
    input  alarm, target_valid, set_err, day_wrap
  );

  modport slave (
    input  tick, set_en, set_time, start, stop,
    input  target_load, target_time, alarm_ack,
    output oHour10, oHour1, oMinute10, oMinute1,
    output oSecond10, oSecond1,
    output alarm, target_valid, set_err, day_wrap
  );

endinterface

// File: rtl/bcd_time_incr.sv
// Combinational +1 second on a packed BCD HH:MM:SS word,
// flagging the 23:59:59 -> 00:00:00 wrap.
module bcd_time_incr
  import time_pkg::*;
(
  input  logic [23:0] cur_i,
  output logic [23:0] nxt_o,
  output logic        wrap_o
);

  logic [3:0] h10, h1, m10, m1, s10, s1;

  always_comb begin
    h10    = cur_i[H10_LSB +: 4];
    h1     = cur_i[H1_LSB +: 4];
    m10    = cur_i[M10_LSB +: 4];
    m1     = cur_i[M1_LSB +: 4];
    s10    = cur_i[S10_LSB +: 4];
    s1     = cur_i[S1_LSB +: 4];
    wrap_o = 1'b0;
    if (s1 != DMAX9) s1 = s1 + 4'd1;
    else begin
      s1 = 4'd0;
      if (s10 != DMAX5) s10 = s10 + 4'd1;
      else begin
        s10 = 4'd0;
        if (m1 != DMAX9) m1 = m1 + 4'd1;
        else begin
          m1 = 4'd0;
          if (m10 != DMAX5) m10 = m10 + 4'd1;
          else begin
            m10 = 4'd0;
            if ((h10 == DMAX2) && (h1 == DMAX3)) begin
              h10    = 4'd0;
              h1     = 4'd0;
              wrap_o = 1'b1;
            end else if (h1 == DMAX9) begin
              h1  = 4'd0;
              h10 = h10 + 4'd1;
            end else begin
              h1 = h1 + 4'd1;
            end
          end
        end
      end
    end
  end

  assign nxt_o = {h10, h1, m10, m1, s10, s1};

endmodule

// File: rtl/nap_clock.sv
// Nap clock: BCD time of day with set/start/stop control and a
// one-shot alarm that rings when the running time meets the target.
module nap_clock
  import time_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        set_en,
  input  logic [23:0] set_time,
  input  logic        start,
  input  logic        stop,
  input  logic        target_load,
  input  logic [23:0] target_time,
  input  logic        alarm_ack,
  output logic [3:0]  oHour10,
  output logic [3:0]  oHour1,
  output logic [3:0]  oMinute10,
  output logic [3:0]  oMinute1,
  output logic [3:0]  oSecond10,
  output logic [3:0]  oSecond1,
  output logic        alarm,
  output logic        target_valid,
  output logic        set_err,
  output logic        day_wrap
);

  state_e      state_q, state_d;
  logic [23:0] time_q, tgt_q, incr_nxt;
  logic        tvld_q, alarm_q, err_q, wrap_q;
  logic        incr_wrap, set_ok, tgt_ok, match;

  bcd_time_incr u_incr (
    .cur_i  (time_q),
    .nxt_o  (incr_nxt),
    .wrap_o (incr_wrap)
  );

  assign set_ok = time_legal(set_time);
  assign tgt_ok = time_legal(target_time);
  assign match  = tvld_q && (time_q == tgt_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STOP: if (start && !stop) state_d = ST_RUN;
      ST_RUN: begin
        if (stop)       state_d = ST_STOP;
        else if (match) state_d = ST_RING;
      end
      ST_RING: begin
        if (stop)           state_d = ST_STOP;
        else if (alarm_ack) state_d = ST_RUN;
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_STOP;
      time_q  <= '0;
      tgt_q   <= '0;
      tvld_q  <= 1'b0;
      alarm_q <= 1'b0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      err_q  <= (set_en && !set_ok) ||
                (target_load && !tgt_ok);
      wrap_q <= 1'b0;
      // A load always beats a tick landing in the same cycle.
      if (set_en) begin
        if (set_ok) time_q <= set_time;
      end else if (tick && (state_q != ST_STOP)) begin
        time_q <= incr_nxt;
        wrap_q <= incr_wrap;
      end
      if (target_load) begin
        if (tgt_ok) tgt_q <= target_time;
        tvld_q <= tgt_ok;
      end else if ((state_q == ST_RING) && alarm_ack) begin
        tvld_q <= 1'b0;
      end
      state_q <= state_d;
      alarm_q <= (state_d == ST_RING);
    end
  end

  assign oHour10      = time_q[H10_LSB +: 4];
  assign oHour1       = time_q[H1_LSB +: 4];
  assign oMinute10    = time_q[M10_LSB +: 4];
  assign oMinute1     = time_q[M1_LSB +: 4];
  assign oSecond10    = time_q[S10_LSB +: 4];
  assign oSecond1     = time_q[S1_LSB +: 4];
  assign alarm        = alarm_q;
  assign target_valid = tvld_q;
  assign set_err      = err_q;
  assign day_wrap     = wrap_q;

endmodule

// File: tb/tb_nap_clock.sv
// Bench for nap_clock: directed scenarios plus random traffic
// checked every cycle against a seconds-of-day reference model.
module tb_nap_clock;

  logic clock;
  logic rst;
  nap_clock_if bus ();

  nap_clock dut (
    .clock        (clock),
    .reset        (rst),
    .tick         (bus.tick),
    .set_en       (bus.set_en),
    .set_time     (bus.set_time),
    .start        (bus.start),
    .stop         (bus.stop),
    .target_load  (bus.target_load),
    .target_time  (bus.target_time),
    .alarm_ack    (bus.alarm_ack),
    .oHour10      (bus.oHour10),
    .oHour1       (bus.oHour1),
    .oMinute10    (bus.oMinute10),
    .oMinute1     (bus.oMinute1),
    .oSecond10    (bus.oSecond10),
    .oSecond1     (bus.oSecond1),
    .alarm        (bus.alarm),
    .target_valid (bus.target_valid),
    .set_err      (bus.set_err),
    .day_wrap     (bus.day_wrap)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  logic [23:0] dut_time;
  assign dut_time = {bus.oHour10, bus.oHour1, bus.oMinute10,
                     bus.oMinute1, bus.oSecond10, bus.oSecond1};

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic int dig(input logic [23:0] t, input int k);
    logic [23:0] v;
    v = t >> (4 * k);
    return int'(v[3:0]);
  endfunction

  function automatic bit legal(input logic [23:0] t);
    bit ok;
    ok = 1;
    for (int k = 0; k < 6; k++) if (dig(t, k) > 9) ok = 0;
    if (dig(t, 5) * 10 + dig(t, 4) > 23) ok = 0;
    if (dig(t, 3) > 5 || dig(t, 1) > 5) ok = 0;
    return ok;
  endfunction

  function automatic int to_secs(input logic [23:0] t);
    return (dig(t, 5) * 10 + dig(t, 4)) * 3600 +
           (dig(t, 3) * 10 + dig(t, 2)) * 60 +
           dig(t, 1) * 10 + dig(t, 0);
  endfunction

  // Reference model: 0 = stopped, 1 = running, 2 = ringing.
  int m_secs, m_tgt, m_mode;
  bit m_vld, m_alarm, m_err, m_wrap;

  always @(posedge clock) begin : model
    int ns, nmode;
    bit nvld, nwrap, hit;
    if (rst) begin
      m_secs <= 0; m_tgt <= 0; m_mode <= 0;
      m_vld <= 0; m_alarm <= 0; m_err <= 0; m_wrap <= 0;
    end else begin
      ns = m_secs; nmode = m_mode; nvld = m_vld; nwrap = 0;
      hit = m_vld && (m_secs == m_tgt);
      if (bus.set_en) begin
        if (legal(bus.set_time)) ns = to_secs(bus.set_time);
      end else if (bus.tick && m_mode != 0) begin
        ns = (m_secs + 1) % 86400;
        nwrap = (ns == 0);
      end
      if (bus.stop) nmode = 0;
      else if (m_mode == 0 && bus.start) nmode = 1;
      else if (m_mode == 1 && hit) nmode = 2;
      else if (m_mode == 2 && bus.alarm_ack) nmode = 1;
      if (bus.target_load) begin
        nvld = legal(bus.target_time);
        if (nvld) m_tgt <= to_secs(bus.target_time);
      end else if (m_mode == 2 && bus.alarm_ack) nvld = 0;
      m_err <= (bus.set_en && !legal(bus.set_time)) ||
               (bus.target_load && !legal(bus.target_time));
      m_secs <= ns; m_mode <= nmode; m_vld <= nvld;
      m_wrap <= nwrap; m_alarm <= (nmode == 2);
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("time", 32'(dut_time), 32'(to_bcd(m_secs)));
      chk("alarm", 32'(bus.alarm), 32'(m_alarm));
      chk("target_valid", 32'(bus.target_valid), 32'(m_vld));
      chk("set_err", 32'(bus.set_err), 32'(m_err));
      chk("day_wrap", 32'(bus.day_wrap), 32'(m_wrap));
    end
  end

  task automatic step();
    @(negedge clock);
    rst = 0; bus.tick = 0; bus.set_en = 0; bus.start = 0;
    bus.stop = 0; bus.target_load = 0; bus.alarm_ack = 0;
  endtask

  task automatic set_t(input logic [23:0] t);
    bus.set_en = 1; bus.set_time = t; step();
  endtask

  task automatic load_t(input logic [23:0] t);
    bus.target_load = 1; bus.target_time = t; step();
  endtask

  task automatic tk();
    bus.tick = 1; step();
  endtask

  initial begin
    rst = 1; bus.tick = 0; bus.set_en = 0; bus.set_time = '0;
    bus.start = 0; bus.stop = 0; bus.target_load = 0;
    bus.target_time = '0; bus.alarm_ack = 0;
    step();
    chk_en = 1;
    chk("rst_time", 32'(dut_time), 32'h0);
    chk("rst_alarm", 32'(bus.alarm), 32'h0);
    chk("rst_valid", 32'(bus.target_valid), 32'h0);

    set_t(24'h123458);
    bus.start = 1; step();
    tk(); tk();
    chk("carry_time", 32'(dut_time), 32'h123500);
    chk("carry_nowrap", 32'(bus.day_wrap), 32'h0);
    chk("model_pin", 32'(to_bcd(m_secs)), 32'h123500);

    set_t(24'h235959);
    tk();
    chk("wrap_time", 32'(dut_time), 32'h0);
    chk("wrap_pulse", 32'(bus.day_wrap), 32'h1);
    step();
    chk("wrap_once", 32'(bus.day_wrap), 32'h0);

    set_t(24'h010203);
    set_t(24'h240000);
    chk("bad_set_time", 32'(dut_time), 32'h010203);
    chk("bad_set_err", 32'(bus.set_err), 32'h1);
    step();
    chk("bad_set_err_1cyc", 32'(bus.set_err), 32'h0);
    load_t(24'h050000);
    chk("tgt_armed", 32'(bus.target_valid), 32'h1);
    load_t(24'h999999);
    chk("tgt_sat_valid", 32'(bus.target_valid), 32'h0);
    chk("tgt_sat_err", 32'(bus.set_err), 32'h1);

    set_t(24'h065958);
    load_t(24'h070000);
    tk(); tk();
    chk("nap_time", 32'(dut_time), 32'h070000);
    chk("nap_not_yet", 32'(bus.alarm), 32'h0);
    step();
    chk("nap_ring", 32'(bus.alarm), 32'h1);
    bus.alarm_ack = 1; step();
    chk("ack_alarm", 32'(bus.alarm), 32'h0);
    chk("ack_valid", 32'(bus.target_valid), 32'h0);
    tk();
    chk("ack_counts", 32'(dut_time), 32'h070001);

    bus.tick = 1; set_t(24'h100000);
    chk("set_beats_tick", 32'(dut_time), 32'h100000);
    step();
    chk("tick_dropped", 32'(dut_time), 32'h100000);

    load_t(24'h100002);
    tk(); tk(); step();
    chk("ring2", 32'(bus.alarm), 32'h1);
    bus.alarm_ack = 1; load_t(24'h100004);
    chk("rearm_alarm", 32'(bus.alarm), 32'h0);
    chk("rearm_valid", 32'(bus.target_valid), 32'h1);
    tk(); tk(); step();
    chk("ring3", 32'(bus.alarm), 32'h1);
    rst = 1; step();
    chk("ringrst_time", 32'(dut_time), 32'h0);
    chk("ringrst_alarm", 32'(bus.alarm), 32'h0);
    chk("ringrst_valid", 32'(bus.target_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tk();
      chk("stop_ignores_tick", 32'(dut_time), 32'h0);
      chk("stop_no_ring", 32'(bus.alarm), 32'h0);
    end
    bus.start = 1; step();
    tk(); tk(); tk();
    chk("rst_no_rering", 32'(bus.alarm), 32'h0);
    chk("run_after_rst", 32'(dut_time), 32'h000003);

    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      bus.tick = $urandom_range(0, 1) == 1;
      bus.start = ($urandom_range(0, 15) == 0);
      bus.stop = ($urandom_range(0, 59) == 0);
      bus.alarm_ack = ($urandom_range(0, 7) == 0);
      bus.set_en = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) bus.set_time = 24'($urandom());
      else if ($urandom_range(0, 1) == 0)
        bus.set_time = to_bcd(m_tgt);
      else bus.set_time = to_bcd($urandom_range(0, 86399));
      bus.target_load = ($urandom_range(0, 23) == 0);
      if ($urandom_range(0, 4) == 0) bus.target_time = 24'($urandom());
      else bus.target_time =
        to_bcd((m_secs + $urandom_range(0, 4)) % 86400);
      @(negedge clock);
    end
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
